concat_packer: RTL and testbench



---
 rtl/concat_packer.sv | 120 ++++++++++++
 tb/tb_concat_packer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/concat_packer.sv
// concat_packer: packs RATIO consecutive IN_W-bit words into one
// OUT_W = IN_W*RATIO word. Both sides use a valid/ready handshake.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and data stable until it sees ready. This
// block holds out_data/out_valid stable while out_valid=1 and out_ready=0.
//
// Optional build macro: CONCAT_PACKER_FLUSH_EN. It adds a flush input that
// emits a partial word (unfilled slots are zero) and an out_cnt output that
// reports how many words in out_data are valid.
module concat_packer #(
  parameter int IN_W      = 4,
  parameter int RATIO     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [IN_W*RATIO-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef CONCAT_PACKER_FLUSH_EN
  ,
  input  logic                    flush,
  output logic [$clog2(RATIO):0]  out_cnt
`endif
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO);
  localparam logic [CW-1:0] LAST_SLOT = CW'(RATIO - 1);

  logic [CW-1:0]    cnt;
  logic [OUT_W-1:0] asm_q;
  logic [OUT_W-1:0] asm_next;
  logic             out_free;
  logic             in_fire;
  logic             last_fire;
  logic             emit;

  // The output register can take a new word when it is empty or being drained.
  assign out_free  = ~out_valid | out_ready;
  assign in_fire   = in_valid & in_ready;
  assign last_fire = in_fire & (cnt == LAST_SLOT);

`ifdef CONCAT_PACKER_FLUSH_EN
  localparam int CNT_W = CW + 1;
  logic             flush_block;
  logic             flush_emit;
  logic [CNT_W-1:0] emit_cnt;

  // A flush that cannot complete stalls the input so that the partial word
  // is not extended behind the consumer's back.
  assign flush_block = flush & ~out_free;
  assign in_ready    = ((cnt != LAST_SLOT) | out_free) & ~flush_block;
  assign flush_emit  = flush & out_free & ((cnt != '0) | in_fire);
  assign emit        = last_fire | flush_emit;
  assign emit_cnt    = last_fire ? CNT_W'(RATIO)
                                 : ({1'b0, cnt} + CNT_W'(in_fire));
`else
  // Non-last slots are always accepted; the last slot needs room at the output.
  assign in_ready = (cnt != LAST_SLOT) | out_free;
  assign emit     = last_fire;
`endif

  // Merge an accepted word into its slot of the assembly register.
  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < RATIO; k++) begin
      if (in_fire && (cnt == CW'(k))) begin
        if (MSB_FIRST != 0) begin
          asm_next[OUT_W-(k+1)*IN_W +: IN_W] = in_data;
        end else begin
          asm_next[k*IN_W +: IN_W] = in_data;
        end
      end
    end
  end

  // Slot counter and assembly register; both clear when a word is emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (emit) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (in_fire) begin
      cnt   <= cnt + CW'(1);
      asm_q <= asm_next;
    end
  end

  // Output register: load on emit, release on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (emit) begin
      out_data  <= asm_next;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef CONCAT_PACKER_FLUSH_EN
  // Word count travels with out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else if (emit) begin
      out_cnt <= emit_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_concat_packer.sv
// Directed testbench for concat_packer (IN_W=4, RATIO=2 in both bit orders;
// RATIO=4 flush instance when CONCAT_PACKER_FLUSH_EN is defined).
module tb_concat_packer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // MSB-first, RATIO=2 instance
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;

  // LSB-first, RATIO=2 instance
  logic [3:0] l_in_data = '0;
  logic       l_in_valid = 1'b0;
  logic       l_in_ready;
  logic [7:0] l_out_data;
  logic       l_out_valid;

  logic [7:0] exp_q[$];

`ifdef CONCAT_PACKER_FLUSH_EN
  logic [1:0]  m_out_cnt;
  logic [1:0]  l_out_cnt;
  logic [3:0]  f_in_data = '0;
  logic        f_in_valid = 1'b0;
  logic        f_in_ready;
  logic [15:0] f_out_data;
  logic        f_out_valid;
  logic        f_flush = 1'b0;
  logic [2:0]  f_out_cnt;
`endif

  concat_packer #(.IN_W(4), .RATIO(2), .MSB_FIRST(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef CONCAT_PACKER_FLUSH_EN
    , .flush(1'b0), .out_cnt(m_out_cnt)
`endif
  );

  concat_packer #(.IN_W(4), .RATIO(2), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .out_data(l_out_data), .out_valid(l_out_valid), .out_ready(1'b1)
`ifdef CONCAT_PACKER_FLUSH_EN
    , .flush(1'b0), .out_cnt(l_out_cnt)
`endif
  );

`ifdef CONCAT_PACKER_FLUSH_EN
  concat_packer #(.IN_W(4), .RATIO(4), .MSB_FIRST(1)) u_r4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(f_in_data), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .out_data(f_out_data), .out_valid(f_out_valid), .out_ready(1'b1),
    .flush(f_flush), .out_cnt(f_out_cnt)
  );
`endif

  // ---------------- driver tasks ----------------
  // Present one word; returns #1 after the edge that accepted it.
  task automatic send(input logic [3:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required=1 for word 0x%0h", in_ready, d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%0b data=0x%0h ready=%0b required 0/0x00/1",
               out_valid, out_data, in_ready);
    end
    #22;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    send(4'h5);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_half_word: out_valid=%0b required=0", out_valid);
    end
    send(4'hF);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h5F) begin
      errors++;
      $display("FAIL basic_5F: valid=%0b data=0x%0h required 1/0x5f", out_valid, out_data);
    end
    send(4'hA);
    send(4'h0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA0) begin
      errors++;
      $display("FAIL basic_A0: valid=%0b data=0x%0h required 1/0xa0", out_valid, out_data);
    end
    send(4'hB);
    send(4'h6);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB6) begin
      errors++;
      $display("FAIL basic_B6: valid=%0b data=0x%0h required 1/0xb6", out_valid, out_data);
    end
  endtask

  task automatic test_lsb_first;
    l_in_data  = 4'h5;
    l_in_valid = 1'b1;
    @(posedge clk);
    #1;
    l_in_data = 4'hF;
    @(posedge clk);
    #1;
    l_in_valid = 1'b0;
    checks++;
    if (l_out_valid !== 1'b1 || l_out_data !== 8'hF5) begin
      errors++;
      $display("FAIL lsb_F5: valid=%0b data=0x%0h required 1/0xf5", l_out_valid, l_out_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp;
    logic [3:0] prev;
    out_ready = 1'b1;
    prev = 4'h0;
    for (int i = 1; i <= 8; i++) begin
      in_data  = 4'(i);
      in_valid = 1'b1;
      if (i % 2 == 0) exp_q.push_back({prev, 4'(i)});
      prev = 4'(i);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready word %0d: in_ready=%0b required=1", i, in_ready);
      end
      @(posedge clk);
      #1;
      if (i % 2 == 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
          errors++;
          $display("FAIL b2b_out word %0d: valid=%0b data=0x%0h required 1/0x%0h",
                   i, out_valid, out_data, exp);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_gap word %0d: out_valid=%0b required=0", i, out_valid);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_queue: %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b1;
    send(4'h1);
    send(4'h2);
    out_ready = 1'b0;
    in_data   = 4'h3;
    in_valid  = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_slot0_ready: in_ready=%0b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_data = 4'h4;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_last_blocked: in_ready=%0b required=0", in_ready);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h12) begin
      errors++;
      $display("FAIL bp_hold: ready=%0b valid=%0b data=0x%0h required 0/1/0x12",
               in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: in_ready=%0b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h34) begin
      errors++;
      $display("FAIL bp_34: valid=%0b data=0x%0h required 1/0x34", out_valid, out_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h34) begin
      errors++;
      $display("FAIL bp_drain_hold: valid=%0b data=0x%0h required 0/0x34", out_valid, out_data);
    end
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b0;
    send(4'h1);
    send(4'h2);
    send(4'h9);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: valid=%0b data=0x%0h ready=%0b required 0/0x00/1",
               out_valid, out_data, in_ready);
    end
    @(negedge clk);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(4'h1);
    send(4'h2);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h12) begin
      errors++;
      $display("FAIL reset_discard: valid=%0b data=0x%0h required 1/0x12", out_valid, out_data);
    end
  endtask

`ifdef CONCAT_PACKER_FLUSH_EN
  task automatic test_flush;
    f_in_valid = 1'b1;
    f_in_data  = 4'hA;
    @(posedge clk);
    #1;
    f_in_data = 4'hB;
    @(posedge clk);
    #1;
    f_in_valid = 1'b0;
    f_flush    = 1'b1;
    @(posedge clk);
    #1;
    f_flush = 1'b0;
    checks++;
    if (f_out_valid !== 1'b1 || f_out_data !== 16'hAB00 || f_out_cnt !== 3'd2) begin
      errors++;
      $display("FAIL flush_partial: valid=%0b data=0x%0h cnt=%0d required 1/0xab00/2",
               f_out_valid, f_out_data, f_out_cnt);
    end
    f_flush = 1'b1;
    @(posedge clk);
    #1;
    f_flush = 1'b0;
    checks++;
    if (f_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_empty: out_valid=%0b required=0", f_out_valid);
    end
    f_in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      f_in_data = 4'(i);
      @(posedge clk);
      #1;
    end
    f_in_valid = 1'b0;
    checks++;
    if (f_out_valid !== 1'b1 || f_out_data !== 16'h1234 || f_out_cnt !== 3'd4) begin
      errors++;
      $display("FAIL flush_full_word: valid=%0b data=0x%0h cnt=%0d required 1/0x1234/4",
               f_out_valid, f_out_data, f_out_cnt);
    end
  endtask
`endif

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_basic();
    test_lsb_first();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
`ifdef CONCAT_PACKER_FLUSH_EN
    test_flush();
`endif
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL global_timeout: simulation time exceeded");
    $fatal(1, "timeout");
  end

endmodule
